// File: rtl/core_regfile_banked.sv
// core_regfile_banked: Cortex-M0 core register file with banked MSP/PSP,
// LR, PC sequencing, SP adjust and APSR/IPSR/PRIMASK/SPSEL.
// Ports:
//   clk, rst (async, active-high)
//   rd_addr/rd_data : NUM_RD packed combinational read ports
//   we_a/wa_*, we_b/wb_* : two write ports, A wins on conflict
//   pc_inc, pc_load/pc_target : PC sequencing
//   sp_adj_en/sp_adj : signed adjust of active SP
//   flags_*, ipsr_*, primask_*, spsel_* : special register writes
//   pc_out, sp_out, lr_out, apsr_out, ipsr_out, primask_out, spsel_out
module core_regfile_banked #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD = 4,
  parameter int BYPASS = 1,
  parameter int PC_STEP = 2,
  parameter int PC_RD_OFS = 4,
  parameter logic [DATA_W-1:0] RST_PC = '0,
  parameter logic [DATA_W-1:0] RST_MSP = '0,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we_a,
  input  logic [AW-1:0]            wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     we_b,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     pc_inc,
  input  logic                     pc_load,
  input  logic [DATA_W-1:0]        pc_target,
  input  logic                     sp_adj_en,
  input  logic [DATA_W-1:0]        sp_adj,
  input  logic                     flags_we,
  input  logic [3:0]               flags_mask,
  input  logic [3:0]               flags_in,
  input  logic                     ipsr_we,
  input  logic [5:0]               ipsr_in,
  input  logic                     primask_we,
  input  logic                     primask_in,
  input  logic                     spsel_we,
  input  logic                     spsel_in,
  output logic [DATA_W-1:0]        pc_out,
  output logic [DATA_W-1:0]        sp_out,
  output logic [DATA_W-1:0]        lr_out,
  output logic [3:0]               apsr_out,
  output logic [5:0]               ipsr_out,
  output logic                     primask_out,
  output logic                     spsel_out
);

  localparam int NG = NUM_REGS - 3;
  localparam int SP_N = NUM_REGS - 3;
  localparam int LR_N = NUM_REGS - 2;
  localparam int PC_N = NUM_REGS - 1;
  localparam int NV = 2 ** AW;
  localparam logic [AW-1:0] SP_I = AW'(SP_N);
  localparam logic [AW-1:0] LR_I = AW'(LR_N);
  localparam logic [AW-1:0] PC_I = AW'(PC_N);
  localparam logic [DATA_W-1:0] M1 = ~DATA_W'(1);
  localparam logic [DATA_W-1:0] M2 = ~DATA_W'(3);
  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);
  localparam logic [DATA_W-1:0] OFS = DATA_W'(PC_RD_OFS);

  logic [DATA_W-1:0] gpr_q [NG];
  logic [DATA_W-1:0] gpr_d [NG];
  logic [DATA_W-1:0] msp_q, msp_d;
  logic [DATA_W-1:0] psp_q, psp_d;
  logic [DATA_W-1:0] lr_q, lr_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [3:0]        apsr_q, apsr_d;
  logic [5:0]        ipsr_q, ipsr_d;
  logic              prim_q, prim_d;
  logic              spsel_q, spsel_d;

  logic              run;
  logic              a_en, b_en;
  logic              sp_wr, pc_wr;
  logic [DATA_W-1:0] sp_wv, pc_wv;
  logic [DATA_W-1:0] sp_cur, sp_nv;

  // Gating with rst keeps bypassed reads at reset values while rst is high.
  assign run  = ~rst;
  assign a_en = we_a & run;
  assign b_en = we_b & run & ~(we_a & (wa_addr == wb_addr));

  assign sp_cur = spsel_q ? psp_q : msp_q;

  always_comb begin
    for (int i = 0; i < NG; i++) begin
      gpr_d[i] = gpr_q[i];
      if (b_en && wb_addr == AW'(i)) gpr_d[i] = wb_data;
      if (a_en && wa_addr == AW'(i)) gpr_d[i] = wa_data;
    end
    lr_d = lr_q;
    if (b_en && wb_addr == LR_I) lr_d = wb_data;
    if (a_en && wa_addr == LR_I) lr_d = wa_data;

    sp_wr = 1'b0;
    sp_wv = '0;
    if (b_en && wb_addr == SP_I) begin
      sp_wr = 1'b1;
      sp_wv = wb_data;
    end
    if (a_en && wa_addr == SP_I) begin
      sp_wr = 1'b1;
      sp_wv = wa_data;
    end

    pc_wr = 1'b0;
    pc_wv = '0;
    if (b_en && wb_addr == PC_I) begin
      pc_wr = 1'b1;
      pc_wv = wb_data;
    end
    if (a_en && wa_addr == PC_I) begin
      pc_wr = 1'b1;
      pc_wv = wa_data;
    end

    // The SP operation targets the bank selected before this edge.
    sp_nv = sp_cur;
    if (sp_wr) sp_nv = sp_wv & M2;
    else if (sp_adj_en && run) sp_nv = (sp_cur + sp_adj) & M2;
    msp_d = spsel_q ? msp_q : sp_nv;
    psp_d = spsel_q ? sp_nv : psp_q;

    pc_d = pc_q;
    if (pc_load && run) pc_d = pc_target & M1;
    else if (pc_wr) pc_d = pc_wv & M1;
    else if (pc_inc && run) pc_d = pc_q + STEP;

    apsr_d = apsr_q;
    if (flags_we && run)
      apsr_d = (apsr_q & ~flags_mask) | (flags_in & flags_mask);
    ipsr_d = (ipsr_we && run) ? ipsr_in : ipsr_q;
    prim_d = (primask_we && run) ? primask_in : prim_q;
    spsel_d = (spsel_we && run) ? spsel_in : spsel_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NG; i++) gpr_q[i] <= '0;
      msp_q   <= RST_MSP & M2;
      psp_q   <= '0;
      lr_q    <= '1;
      pc_q    <= RST_PC;
      apsr_q  <= '0;
      ipsr_q  <= '0;
      prim_q  <= 1'b0;
      spsel_q <= 1'b0;
    end else begin
      for (int i = 0; i < NG; i++) gpr_q[i] <= gpr_d[i];
      msp_q   <= msp_d;
      psp_q   <= psp_d;
      lr_q    <= lr_d;
      pc_q    <= pc_d;
      apsr_q  <= apsr_d;
      ipsr_q  <= ipsr_d;
      prim_q  <= prim_d;
      spsel_q <= spsel_d;
    end
  end

  // Architectural views of every index, before and after the edge.
  logic [DATA_W-1:0] cur_v [NV];
  logic [DATA_W-1:0] nxt_v [NV];

  always_comb begin
    for (int i = 0; i < NV; i++) begin
      cur_v[i] = '0;
      nxt_v[i] = '0;
    end
    for (int i = 0; i < NG; i++) begin
      cur_v[i] = gpr_q[i];
      nxt_v[i] = gpr_d[i];
    end
    cur_v[SP_N] = sp_cur;
    nxt_v[SP_N] = sp_nv;
    cur_v[LR_N] = lr_q;
    nxt_v[LR_N] = lr_d;
    cur_v[PC_N] = pc_q + OFS;
    nxt_v[PC_N] = pc_d + OFS;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];
    assign rd_data[k*DATA_W +: DATA_W] =
      (BYPASS != 0) ? nxt_v[a] : cur_v[a];
  end

  assign pc_out      = pc_q;
  assign sp_out      = sp_cur;
  assign lr_out      = lr_q;
  assign apsr_out    = apsr_q;
  assign ipsr_out    = ipsr_q;
  assign primask_out = prim_q;
  assign spsel_out   = spsel_q;

endmodule

// File: tb/tb_core_regfile_banked.sv
// Bench for core_regfile_banked: directed vector table, hand sequences
// and random stimulus against a rule-level reference model.
module tb_core_regfile_banked;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int ND = 4;

  logic clk;
  logic rst;
  logic [ND*AW-1:0] rd_addr;
  logic [ND*DW-1:0] rd_data1, rd_data0;
  logic we_a, we_b, pc_inc, pc_load, sp_adj_en;
  logic [AW-1:0] wa_addr, wb_addr;
  logic [DW-1:0] wa_data, wb_data, pc_target, sp_adj;
  logic flags_we, ipsr_we, primask_we, primask_in, spsel_we, spsel_in;
  logic [3:0] flags_mask, flags_in;
  logic [5:0] ipsr_in;
  logic [DW-1:0] pc_out, sp_out, lr_out, pc_out0, sp_out0, lr_out0;
  logic [3:0] apsr_out, apsr_out0;
  logic [5:0] ipsr_out, ipsr_out0;
  logic primask_out, spsel_out, primask_out0, spsel_out0;

  int nerr, nchk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  core_regfile_banked #(.RST_PC(32'h100), .RST_MSP(32'h2003), .BYPASS(1))
  dut1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1),
    .we_a(we_a), .wa_addr(wa_addr), .wa_data(wa_data),
    .we_b(we_b), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
    .sp_adj_en(sp_adj_en), .sp_adj(sp_adj),
    .flags_we(flags_we), .flags_mask(flags_mask), .flags_in(flags_in),
    .ipsr_we(ipsr_we), .ipsr_in(ipsr_in),
    .primask_we(primask_we), .primask_in(primask_in),
    .spsel_we(spsel_we), .spsel_in(spsel_in),
    .pc_out(pc_out), .sp_out(sp_out), .lr_out(lr_out),
    .apsr_out(apsr_out), .ipsr_out(ipsr_out),
    .primask_out(primask_out), .spsel_out(spsel_out)
  );

  core_regfile_banked #(.RST_PC(32'h100), .RST_MSP(32'h2003), .BYPASS(0))
  dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0),
    .we_a(we_a), .wa_addr(wa_addr), .wa_data(wa_data),
    .we_b(we_b), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
    .sp_adj_en(sp_adj_en), .sp_adj(sp_adj),
    .flags_we(flags_we), .flags_mask(flags_mask), .flags_in(flags_in),
    .ipsr_we(ipsr_we), .ipsr_in(ipsr_in),
    .primask_we(primask_we), .primask_in(primask_in),
    .spsel_we(spsel_we), .spsel_in(spsel_in),
    .pc_out(pc_out0), .sp_out(sp_out0), .lr_out(lr_out0),
    .apsr_out(apsr_out0), .ipsr_out(ipsr_out0),
    .primask_out(primask_out0), .spsel_out(spsel_out0)
  );

  // Reference state: r[13] and r[15] unused, SP kept per bank.
  typedef struct packed {
    logic [15:0][DW-1:0] r;
    logic [1:0][DW-1:0]  sp;
    logic [DW-1:0]       pc;
    logic [3:0]          apsr;
    logic [5:0]          ipsr;
    logic                primask;
    logic                spsel;
  } st_t;

  st_t cur, nxt;

  function automatic st_t reset_st();
    st_t s;
    s = '0;
    s.r[14] = '1;
    s.pc = 32'h100;
    s.sp[0] = 32'h2000;
    return s;
  endfunction

  function automatic st_t wr(st_t s, logic [3:0] a, logic [DW-1:0] v,
                             logic bank);
    st_t n;
    n = s;
    if (a == 4'd13) n.sp[bank] = v & ~32'd3;
    else if (a == 4'd15) n.pc = v & ~32'd1;
    else n.r[a] = v;
    return n;
  endfunction

  // Lowest priority first; later rules overwrite earlier ones.
  function automatic st_t model_next();
    st_t n;
    logic b;
    n = cur;
    b = cur.spsel;
    if (sp_adj_en) n.sp[b] = (cur.sp[b] + sp_adj) & ~32'd3;
    if (pc_inc) n.pc = cur.pc + 32'd2;
    if (we_b) n = wr(n, wb_addr, wb_data, b);
    if (we_a) n = wr(n, wa_addr, wa_data, b);
    if (pc_load) n.pc = pc_target & ~32'd1;
    if (flags_we)
      for (int i = 0; i < 4; i++)
        if (flags_mask[i]) n.apsr[i] = flags_in[i];
    if (ipsr_we) n.ipsr = ipsr_in;
    if (primask_we) n.primask = primask_in;
    if (spsel_we) n.spsel = spsel_in;
    return n;
  endfunction

  function automatic logic [DW-1:0] view(st_t s, logic [3:0] a, logic bank);
    if (a == 4'd13) return s.sp[bank];
    if (a == 4'd15) return s.pc + 32'd4;
    return s.r[a];
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we_a = 0; wa_addr = 0; wa_data = 0;
    we_b = 0; wb_addr = 0; wb_data = 0;
    pc_inc = 0; pc_load = 0; pc_target = 0;
    sp_adj_en = 0; sp_adj = 0;
    flags_we = 0; flags_mask = 0; flags_in = 0;
    ipsr_we = 0; ipsr_in = 0;
    primask_we = 0; primask_in = 0;
    spsel_we = 0; spsel_in = 0;
  endtask

  task automatic check_reads(st_t bys, st_t nbs, logic bank);
    for (int k = 0; k < ND; k++) begin
      automatic logic [3:0] a = rd_addr[k*AW +: AW];
      chk($sformatf("rd_byp%0d_a%0d", k, a),
          rd_data1[k*DW +: DW], view(bys, a, bank));
      chk($sformatf("rd_nob%0d_a%0d", k, a),
          rd_data0[k*DW +: DW], view(nbs, a, bank));
    end
  endtask

  task automatic check_outs();
    chk("pc_out", pc_out, cur.pc);
    chk("pc_out_nb", pc_out0, cur.pc);
    chk("sp_out", sp_out, cur.sp[cur.spsel]);
    chk("sp_out_nb", sp_out0, cur.sp[cur.spsel]);
    chk("lr_out", lr_out, cur.r[14]);
    chk("apsr_out", 32'(apsr_out), 32'(cur.apsr));
    chk("ipsr_out", 32'(ipsr_out), 32'(cur.ipsr));
    chk("primask_out", 32'(primask_out), 32'(cur.primask));
    chk("spsel_out", 32'(spsel_out), 32'(cur.spsel));
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic step();
    nxt = model_next();
    #1;
    check_reads(nxt, cur, cur.spsel);
    @(posedge clk);
    #1;
    cur = nxt;
    check_outs();
    @(negedge clk);
  endtask

  typedef struct {
    logic inc, ld;
    logic [DW-1:0] tgt;
    logic wea;
    logic [3:0] waa;
    logic [DW-1:0] wad;
    logic web;
    logic [3:0] wba;
    logic [DW-1:0] wbd;
    logic adj_en;
    logic [DW-1:0] adj;
    logic ssw, ssi;
    logic fw;
    logic [3:0] fm, fi;
    logic [3:0] ra;
    logic [DW-1:0] e_byp, e_nob, e_pc, e_sp, e_lr;
    logic [3:0] e_apsr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [3:0] ra, logic [DW-1:0] byp,
                              logic [DW-1:0] nob, logic [DW-1:0] pc,
                              logic [DW-1:0] sp, logic [DW-1:0] lr,
                              logic [3:0] ap);
    vec_t v;
    v.inc = 0; v.ld = 0; v.tgt = 0;
    v.wea = 0; v.waa = 0; v.wad = 0;
    v.web = 0; v.wba = 0; v.wbd = 0;
    v.adj_en = 0; v.adj = 0; v.ssw = 0; v.ssi = 0;
    v.fw = 0; v.fm = 0; v.fi = 0;
    v.ra = ra; v.e_byp = byp; v.e_nob = nob;
    v.e_pc = pc; v.e_sp = sp; v.e_lr = lr; v.e_apsr = ap;
    return v;
  endfunction

  task automatic apply(vec_t v);
    idle();
    pc_inc = v.inc; pc_load = v.ld; pc_target = v.tgt;
    we_a = v.wea; wa_addr = v.waa; wa_data = v.wad;
    we_b = v.web; wb_addr = v.wba; wb_data = v.wbd;
    sp_adj_en = v.adj_en; sp_adj = v.adj;
    spsel_we = v.ssw; spsel_in = v.ssi;
    flags_we = v.fw; flags_mask = v.fm; flags_in = v.fi;
    rd_addr = {4'd14, 4'd13, 4'd0, v.ra};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    nerr = 0;
    nchk = 0;

    v = mk(15, 'h106, 'h104, 'h102, 'h2000, '1, 0); v.inc = 1; tv.push_back(v);
    v = mk(15, 'h108, 'h106, 'h104, 'h2000, '1, 0); v.inc = 1; tv.push_back(v);
    v = mk(15, 'h10A, 'h108, 'h106, 'h2000, '1, 0); v.inc = 1; tv.push_back(v);
    v = mk(15, 'h204, 'h10A, 'h200, 'h2000, '1, 0);
    v.inc = 1; v.ld = 1; v.tgt = 'h201; tv.push_back(v);
    v = mk(15, 'h204, 'h204, 'h200, 'h2000, '1, 0); tv.push_back(v);
    v = mk(3, 'hAAAA, 0, 'h200, 'h2000, '1, 0);
    v.wea = 1; v.waa = 3; v.wad = 'hAAAA;
    v.web = 1; v.wba = 3; v.wbd = 'h5555; tv.push_back(v);
    v = mk(3, 'hAAAA, 'hAAAA, 'h200, 'h2000, '1, 0); tv.push_back(v);
    v = mk(13, 'h1000, 'h2000, 'h200, 'h1000, '1, 0);
    v.wea = 1; v.waa = 13; v.wad = 'h1000; tv.push_back(v);
    v = mk(13, 'hFF8, 'h1000, 'h200, 0, '1, 0);
    v.ssw = 1; v.ssi = 1; v.adj_en = 1; v.adj = 32'hFFFF_FFF8;
    tv.push_back(v);
    v = mk(13, 0, 0, 'h200, 0, '1, 0); tv.push_back(v);
    v = mk(0, 0, 0, 'h200, 0, '1, 4'hF);
    v.fw = 1; v.fm = 4'hF; v.fi = 4'hF; tv.push_back(v);
    v = mk(0, 0, 0, 'h200, 0, '1, 4'hA);
    v.fw = 1; v.fm = 4'h5; v.fi = 4'h0; tv.push_back(v);
    v = mk(14, 'h12345678, '1, 'h200, 0, 'h12345678, 4'hA);
    v.web = 1; v.wba = 14; v.wbd = 'h12345678; tv.push_back(v);
    v = mk(13, 'h3004, 0, 'h200, 'h3004, 'h12345678, 4'hA);
    v.web = 1; v.wba = 13; v.wbd = 'h3007; tv.push_back(v);
    v = mk(15, 'h304, 'h204, 'h300, 'h3004, 'h12345678, 4'hA);
    v.inc = 1; v.wea = 1; v.waa = 15; v.wad = 'h301; tv.push_back(v);

    idle();
    rd_addr = '0;
    rst = 1'b1;
    cur = reset_st();
    #12;
    check_outs();
    for (int b = 0; b < 16; b += 4) begin
      rd_addr = {4'(b + 3), 4'(b + 2), 4'(b + 1), 4'(b)};
      #1;
      check_reads(cur, cur, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i]);
      #1;
      chk($sformatf("tv%0d_rd_byp", i), rd_data1[DW-1:0], tv[i].e_byp);
      chk($sformatf("tv%0d_rd_nob", i), rd_data0[DW-1:0], tv[i].e_nob);
      step();
      chk($sformatf("tv%0d_pc", i), pc_out, tv[i].e_pc);
      chk($sformatf("tv%0d_sp", i), sp_out, tv[i].e_sp);
      chk($sformatf("tv%0d_lr", i), lr_out, tv[i].e_lr);
      chk($sformatf("tv%0d_apsr", i), 32'(apsr_out), 32'(tv[i].e_apsr));
    end

    // Asynchronous reset mid-cycle with writes still active.
    idle();
    pc_inc = 1; we_a = 1; wa_addr = 3; wa_data = 'h77;
    rd_addr = {4'd14, 4'd13, 4'd15, 4'd3};
    step();
    nxt = model_next();
    @(posedge clk);
    cur = nxt;
    #2;
    rst = 1'b1;
    #1;
    cur = reset_st();
    check_outs();
    check_reads(cur, cur, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_pc", pc_out, 32'h102);

    for (int n = 0; n < 400; n++) begin
      idle();
      we_a = 1'($urandom_range(0, 1));
      wa_addr = 4'($urandom_range(0, 15));
      wa_data = $urandom;
      we_b = 1'($urandom_range(0, 1));
      wb_addr = ($urandom_range(0, 3) == 0) ? wa_addr
                                             : 4'($urandom_range(0, 15));
      wb_data = $urandom;
      pc_inc = 1'($urandom_range(0, 1));
      pc_load = ($urandom_range(0, 7) == 0);
      pc_target = $urandom;
      sp_adj_en = 1'($urandom_range(0, 1));
      sp_adj = ($urandom_range(0, 3) == 0) ? $urandom
               : 32'($urandom_range(0, 63)) - 32'd32;
      flags_we = 1'($urandom_range(0, 1));
      flags_mask = 4'($urandom_range(0, 15));
      flags_in = 4'($urandom_range(0, 15));
      ipsr_we = ($urandom_range(0, 3) == 0);
      ipsr_in = 6'($urandom_range(0, 63));
      primask_we = ($urandom_range(0, 3) == 0);
      primask_in = 1'($urandom_range(0, 1));
      spsel_we = ($urandom_range(0, 3) == 0);
      spsel_in = 1'($urandom_range(0, 1));
      rd_addr = 16'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/core_regfile_banked.md
# core_regfile_banked

Parametrised core register file for the Cortex-M0 datapath: general-purpose registers, banked stack pointer (MSP/PSP), link register, program counter and special registers (APSR, IPSR, PRIMASK, CONTROL.SPSEL). Everything is updated on a single clock edge. It provides a configurable number of combinational read ports with optional write-to-read bypass, two write ports, PC sequencing and SP adjust. It sits between decode/execute and the writeback stage of the core.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, indexed registers (minimum 4). SP = NUM_REGS-3, LR = NUM_REGS-2, PC = NUM_REGS-1. AW = $clog2(NUM_REGS).
- NUM_RD, 4, number of read ports.
- BYPASS, 1, when 1 a read of a register being written this cycle returns the new value.
- PC_STEP, 2, increment applied when pc_inc is asserted.
- PC_RD_OFS, 4, offset added to PC when PC is read via a read port.
- RST_PC, 0, PC reset value.
- RST_MSP, 0, MSP reset value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  packed read data.
- we_a, wa_addr, wa_data  in  1/AW/DATA_W  write port A (ALU result).
- we_b, wb_addr, wb_data  in  1/AW/DATA_W  write port B (load/writeback).
- pc_inc  in  1  PC += PC_STEP.
- pc_load, pc_target  in  1/DATA_W  branch load.
- sp_adj_en, sp_adj  in  1/DATA_W  add sp_adj (two's complement) to the active SP.
- flags_we, flags_mask, flags_in  in  1/4/4  NZCV write, per-bit mask.
- ipsr_we, ipsr_in  in  1/6  exception number.
- primask_we, primask_in  in  1/1.
- spsel_we, spsel_in  in  1/1  0 selects MSP, 1 selects PSP.
- pc_out, sp_out, lr_out  out  DATA_W  PC, active SP, LR.
- apsr_out  out  4  {N,Z,C,V}.
- ipsr_out  out  6.
- primask_out, spsel_out  out  1.

## Operation
- Reset values: R0..R(NUM_REGS-4) = 0, MSP = RST_MSP with bits[1:0] forced to 0, PSP = 0, LR = all ones, PC = RST_PC, APSR = 0, IPSR = 0, PRIMASK = 0, SPSEL = 0. All outputs reflect these values immediately while rst is high.
- Reads are combinational. The SP index returns the active SP. The PC index returns PC+PC_RD_OFS (modulo 2^DATA_W).
- Bypass (BYPASS=1) returns the value the register will hold after the edge, with the same priority as the write. For the PC index the bypassed value is (new PC)+PC_RD_OFS.
- Write port conflict on the same address: port A wins and port B is dropped.
- A general write to the SP index updates the active bank only, with bits[1:0] cleared.
- A general write to the PC index acts as a branch, with bit0 cleared.
- PC priority: rst > pc_load > general write to PC > pc_inc > hold. pc_target bit0 is cleared. The increment wraps at 2^DATA_W.
- SP priority: general write to SP > sp_adj_en > hold. The adjust result has bits[1:0] cleared and wraps modulo 2^DATA_W.
- spsel_we with sp_adj_en or an SP write in the same cycle: the SP operation uses the bank selected before the edge. The new SPSEL takes effect next cycle.
- Flags: only bits with flags_mask=1 are updated. Mask bit order matches {N,Z,C,V}.
- Writes to R0..LR with no enable asserted hold their value.

## Timing
- All state changes on the rising clk edge, one-cycle write latency. New values appear on outputs and rd_data (BYPASS=0) after that edge.
- With BYPASS=1, read data reflects pending writes in the same cycle, zero latency.
- rst asserted mid-cycle clears state immediately; the first edge after deassertion performs normal updates.

## Test plan
- Reset: assert rst with RST_PC=0x100 and RST_MSP=0x2003 -> pc_out=0x100, sp_out=0x2000, lr_out=0xFFFFFFFF, apsr_out=0, all GPRs read 0.
- PC sequencing: 3 cycles of pc_inc from 0x100 -> 0x106. Then pc_load with pc_target=0x201 together with pc_inc -> PC=0x200. Reading the PC index now returns 0x204.
- Port conflict and bypass: we_a and we_b both to R3 with 0xAAAA/0x5555 -> R3=0xAAAA. In the same cycle rd_addr=3 returns 0xAAAA (BYPASS=1); with BYPASS=0 it returns the old value.
- SP banking: set MSP=0x1000, spsel_we=1, spsel_in=1, and sp_adj=-8 in the same cycle -> MSP=0x0FF8, PSP unchanged (0). Next cycle sp_out=PSP=0.
- Flags mask: apsr=0b1111, then flags_we with flags_mask=0b0101 and flags_in=0b0000 -> apsr_out=0b1010.
- Mid-run reset: assert rst asynchronously while pc_inc and we_a are active -> outputs return to reset values before the next clk edge.
